dut_wrap_rr_sched: RTL
======================

// Module: dut_wrap_rr_sched
// PURPOSE
//  Shares the single in1/out1 ready-valid channel pair of dut_wrap among N_REQ requesters.
//  - Round-robin arbitration of requests onto in1.
//  - An in-order tag FIFO records the issuing requester of each in1 transfer.
//  - Each out1 result is steered back to that requester.
//  Sits between the requester fabric and dut_wrap; dut_wrap returns exactly one out1 per in1, in order.
// PARAMETERS
//  N_REQ      4   number of requesters (2..8)
//  W          16  data width of in1/out1 values
//  TAG_DEPTH  4   max outstanding in1 transfers awaiting out1 (power of 2, >=2)
// PORTS
//  clk         in   1        clock, rising edge
//  rst_bar     in   1        async reset, active low
//  req_value   in   N_REQ*W  request data; requester i at [i*W +: W]
//  req_vld     in   N_REQ    request valid per requester
//  req_rdy     out  N_REQ    request ready per requester
//  rsp_value   out  W        response data, shared by all requesters (= out1_value)
//  rsp_vld     out  N_REQ    response valid per requester
//  rsp_rdy     in   N_REQ    response ready per requester
//  in1_value   out  W        to dut_wrap in1
//  in1_vld     out  1        to dut_wrap in1
//  in1_rdy     in   1        from dut_wrap in1
//  out1_value  in   W        from dut_wrap out1
//  out1_vld    in   1        from dut_wrap out1
//  out1_rdy    out  1        to dut_wrap out1
//  outstanding out  clog2(TAG_DEPTH)+1  tag FIFO occupancy
//  orphan_err  out  1        sticky: out1_vld seen while tag FIFO empty
// BEHAVIOUR
//  Reset (async, rst_bar=0)
//  - state=IDLE, gnt=0, last=N_REQ-1, tag FIFO empty, orphan_err=0.
//  - All req_rdy/rsp_vld/in1_vld/out1_rdy=0 immediately, incl. mid-transfer; in-flight tags lost.
//  FSM IDLE
//  - If any req_vld and FIFO not full: gnt <= first set req_vld scanning last+1, last+2, ... mod N_REQ.
//  - Then -> GRANT. No grant when FIFO is full.
//  FSM GRANT
//  - in1_vld=1, in1_value=req_value[gnt], req_rdy[gnt]=in1_rdy; other req_rdy=0.
//  - On in1_vld&in1_rdy: push gnt into FIFO, last<=gnt, -> IDLE.
//  - Requesters hold vld/value stable until rdy (ready-valid rule); gnt stays locked until the handshake.
//  Timing
//  - Issue latency: 1 cycle from req_vld to in1_vld (arbitration bubble).
//  - Peak throughput: 1 transfer per 2 cycles.
//  Response path (combinational from FIFO head h)
//  - FIFO non-empty: rsp_vld[h]=out1_vld, other rsp_vld=0, out1_rdy=rsp_rdy[h].
//  - On out1_vld&out1_rdy: pop.
//  - FIFO empty: out1_rdy=0, all rsp_vld=0; out1_vld=1 sets orphan_err (cleared only by reset).
//  FIFO boundaries
//  - Push and pop in the same cycle: occupancy unchanged, pointers wrap mod TAG_DEPTH.
//  - Full: IDLE waits; no push is possible while full, since a grant requires not-full.
//  - outstanding counts 0..TAG_DEPTH.
//  Throughput on out1 is limited only by rsp_rdy of the head requester.
// CONFIGURATION
//  SCHED_STATS_EN defined
//  - Adds output grant_cnt, N_REQ*16 bits.
//  - Per-requester count of in1 handshakes; saturates at 16'hFFFF; reset to 0.
//  SCHED_STATS_EN undefined
//  - Port and counters absent; all other behaviour identical.
// TESTING
//  T1 single: req_vld=4'b0001, req_value[0]=16'h0001, in1_rdy=1 -> in1_vld 1 cycle later;
//     out1_vld with 16'h00AA -> rsp_vld=4'b0001, rsp_value=16'h00AA.
//  T2 fairness: all 4 req_vld held, in1_rdy=out1_rdy path open -> grant order 0,1,2,3,0; each grant_cnt=2 after 8 issues.
//  T3 backpressure: in1_rdy=0 for 5 cycles in GRANT -> gnt/in1_value stable, req_rdy=0;
//     in1_rdy=1 -> one push, outstanding=1.
//  T4 full: out1_vld=0, 6 requests -> outstanding stops at 4, in1_vld=0 in IDLE;
//     one out1 pop -> next grant issued.
//  T5 ordering: requesters 2 then 0 issue; out1 16'h0022 then 16'h0000 -> rsp_vld 4'b0100 then 4'b0001;
//     rsp_rdy[2]=0 stalls out1_rdy.
//  T6 reset/orphan: rst_bar=0 in GRANT -> in1_vld=0 same cycle, outstanding=0;
//     after release out1_vld=1 -> orphan_err=1, out1_rdy=0.

Source files
------------

// File: rtl/dut_wrap_rr_sched.sv
// Round-robin scheduler sharing dut_wrap's in1/out1 channel pair among N_REQ requesters.
// Define SCHED_STATS_EN to add the per-requester grant_cnt output.
module dut_wrap_rr_sched #(
  parameter int N_REQ     = 4,
  parameter int W         = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_bar,
  input  logic [N_REQ*W-1:0]             req_value,
  input  logic [N_REQ-1:0]               req_vld,
  output logic [N_REQ-1:0]               req_rdy,
  output logic [W-1:0]                   rsp_value,
  output logic [N_REQ-1:0]               rsp_vld,
  input  logic [N_REQ-1:0]               rsp_rdy,
  output logic [W-1:0]                   in1_value,
  output logic                           in1_vld,
  input  logic                           in1_rdy,
  input  logic [W-1:0]                   out1_value,
  input  logic                           out1_vld,
  output logic                           out1_rdy,
  output logic [$clog2(TAG_DEPTH):0]     outstanding,
  output logic                           orphan_err
`ifdef SCHED_STATS_EN
  ,
  output logic [N_REQ*16-1:0]            grant_cnt
`endif
);

  localparam int GW = $clog2(N_REQ);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   last_q, last_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            orphan_q, orphan_d;
  logic [GW-1:0]   tag_mem [TAG_DEPTH];

  logic            arb_found;
  logic [GW-1:0]   arb_pick;
  logic [GW-1:0]   arb_idx;
  logic            fifo_full;
  logic            fifo_empty;
  logic [GW-1:0]   head;
  logic            push;
  logic            pop;

  assign fifo_full  = (count_q == CW'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = tag_mem[rd_ptr_q];

  // Scan last+1, last+2, ... so the most recent winner has lowest priority.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    arb_found = 1'b0;
    arb_pick  = last_q;
    arb_idx   = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      arb_idx = GW'((int'(last_q) + k) % N_REQ);
      if (!arb_found && req_vld[arb_idx]) begin
        arb_found = 1'b1;
        arb_pick  = arb_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_found && !fifo_full) begin
          gnt_d   = arb_pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (in1_rdy) begin
          push    = 1'b1;
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue side: only the locked grant sees in1_rdy.
  always_comb begin
    in1_vld   = (state_q == ST_GRANT);
    in1_value = '0;
    req_rdy   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q == GW'(i)) begin
        in1_value = req_value[i*W +: W];
        if (state_q == ST_GRANT) req_rdy[i] = in1_rdy;
      end
    end
  end

  // Response side: steer out1 to the requester recorded at the FIFO head.
  always_comb begin
    rsp_vld  = '0;
    out1_rdy = 1'b0;
    if (!fifo_empty) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (head == GW'(i)) begin
          rsp_vld[i] = out1_vld;
          out1_rdy   = rsp_rdy[i];
        end
      end
    end
  end

  assign pop       = out1_vld && out1_rdy;
  assign rsp_value = out1_value;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    orphan_d = orphan_q | (out1_vld && fifo_empty);
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      last_q   <= GW'(N_REQ - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      orphan_q <= orphan_d;
    end
  end

  // NOTE: tag storage has no reset; entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= gnt_q;
  end

  assign outstanding = count_q;
  assign orphan_err  = orphan_q;

`ifdef SCHED_STATS_EN
  logic [N_REQ-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (push && gnt_q == GW'(i) && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
